// File: rtl/ex_stage_sequencer.sv
// Execute-stage pipeline sequencer: turns EX redirects into a registered PC load
// with a timed IF/ID + ID/EX flush window, and holds the front end during multi-cycle MD ops.
module ex_stage_sequencer #(
  parameter int MD_CYCLES   = 32,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exValid,
  input  logic        branchF,
  input  logic        branchTaken,
  input  logic        jumpF,
  input  logic        jumpRF,
  input  logic [31:0] toPC,
  input  logic        mdReqF,
  input  logic        memStallF,
  output logic        pcWriteF,
  output logic        pcLoadF,
  output logic [31:0] newPC,
  output logic        flushIFID,
  output logic        flushIDEX,
  output logic        stallIFID,
  output logic        stallIDEX,
  output logic        mdStartF,
  output logic        mdBusyF,
  output logic        mdDoneF,
  output logic [1:0]  state
);

  // state | meaning
  // RUN   | normal flow; accepts stalls, MD starts and redirects
  // MD    | multiply/divide occupies EX; front end held
  // FLUSH | redirect flush window; PC loaded on its first cycle

  localparam int CMAX = (MD_CYCLES > FLUSH_SLOTS) ? MD_CYCLES : FLUSH_SLOTS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] MD_LAST = CW'(MD_CYCLES - 1);
  localparam logic [CW-1:0] FL_LAST = CW'(FLUSH_SLOTS - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_MD    = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   new_pc_q, new_pc_d;
  logic          md_ack_q, md_ack_d;
  logic          redirect;

  assign redirect = exValid & (jumpRF | jumpF | (branchF & branchTaken));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    new_pc_d  = new_pc_q;
    md_ack_d  = md_ack_q;
    pcWriteF  = 1'b0;
    pcLoadF   = 1'b0;
    flushIFID = 1'b0;
    flushIDEX = 1'b0;
    stallIFID = 1'b0;
    stallIDEX = 1'b0;
    mdStartF  = 1'b0;
    mdBusyF   = 1'b0;
    mdDoneF   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (memStallF) begin
          stallIFID = 1'b1;
          stallIDEX = 1'b1;
        end else begin
          // ack only survives the single RUN cycle after an MD op completes
          md_ack_d = 1'b0;
          if (exValid && mdReqF && !md_ack_q) begin
            mdStartF  = 1'b1;
            stallIFID = 1'b1;
            stallIDEX = 1'b1;
            cnt_d     = MD_LAST;
            state_d   = S_MD;
          end else if (redirect) begin
            new_pc_d  = toPC;
            flushIFID = 1'b1;
            flushIDEX = 1'b1;
            cnt_d     = FL_LAST;
            state_d   = S_FLUSH;
          end else begin
            pcWriteF = 1'b1;
          end
        end
      end

      S_MD: begin
        mdBusyF   = 1'b1;
        stallIFID = 1'b1;
        stallIDEX = 1'b1;
        if (cnt_q == '0) begin
          mdDoneF  = 1'b1;
          md_ack_d = 1'b1;
          state_d  = S_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FLUSH: begin
        flushIFID = 1'b1;
        flushIDEX = 1'b1;
        pcLoadF   = (cnt_q == FL_LAST);
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      new_pc_q <= '0;
      md_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
      md_ack_q <= md_ack_d;
    end
  end

  assign newPC = new_pc_q;
  assign state = state_q;

endmodule

// File: tb/tb_ex_stage_sequencer.sv
// Scoreboard bench for ex_stage_sequencer: directed scenarios plus randomized traffic
// checked against a cycles-remaining reference model.
module tb_ex_stage_sequencer;
  localparam int MD_N = 32;
  localparam int FS_N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exValid = 1'b0, branchF = 1'b0, branchTaken = 1'b0, jumpF = 1'b0, jumpRF = 1'b0;
  logic [31:0] toPC = '0;
  logic        mdReqF = 1'b0, memStallF = 1'b0;
  logic        pcWriteF, pcLoadF, flushIFID, flushIDEX, stallIFID, stallIDEX;
  logic        mdStartF, mdBusyF, mdDoneF;
  logic [31:0] newPC;
  logic [1:0]  state;

  ex_stage_sequencer #(.MD_CYCLES(MD_N), .FLUSH_SLOTS(FS_N)) dut (
    .clk(clk), .reset(reset), .exValid(exValid), .branchF(branchF),
    .branchTaken(branchTaken), .jumpF(jumpF), .jumpRF(jumpRF), .toPC(toPC),
    .mdReqF(mdReqF), .memStallF(memStallF), .pcWriteF(pcWriteF), .pcLoadF(pcLoadF),
    .newPC(newPC), .flushIFID(flushIFID), .flushIDEX(flushIDEX), .stallIFID(stallIFID),
    .stallIDEX(stallIDEX), .mdStartF(mdStartF), .mdBusyF(mdBusyF), .mdDoneF(mdDoneF),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int dut_starts = 0;
  int dut_dones = 0;

  logic [42:0] exp_q[$];
  logic [31:0] tgt_q[$];

  // model: cycles left in the MD op, cycles left in the flush window, etc.
  int          m_md_rem, m_fl_rem;
  bit          m_fl_first, m_ack;
  logic [31:0] m_tgt;

  function automatic logic [42:0] dut_vec();
    return {pcWriteF, pcLoadF, flushIFID, flushIDEX, stallIFID, stallIDEX,
            mdStartF, mdBusyF, mdDoneF, state, newPC};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_md_rem = 0; m_fl_rem = 0; m_fl_first = 0; m_ack = 0; m_tgt = '0;
  endtask

  // expected outputs for the current cycle, then advance the model
  task automatic model_step(output logic [42:0] v);
    bit pw, pl, fi, fe, si, se, ms, mb, md;
    logic [1:0] st;
    bit redir;
    pw = 0; pl = 0; fi = 0; fe = 0; si = 0; se = 0; ms = 0; mb = 0; md = 0;
    redir = exValid && (jumpRF || jumpF || (branchF && branchTaken));
    if (m_md_rem > 0) begin
      st = 2'd1; mb = 1; si = 1; se = 1;
      md = (m_md_rem == 1);
      m_md_rem--;
      if (md) m_ack = 1;
    end else if (m_fl_rem > 0) begin
      st = 2'd2; fi = 1; fe = 1;
      pl = m_fl_first;
      m_fl_first = 0;
      m_fl_rem--;
    end else begin
      st = 2'd0;
      if (memStallF) begin
        si = 1; se = 1;
      end else if (exValid && mdReqF && !m_ack) begin
        ms = 1; si = 1; se = 1; m_md_rem = MD_N; m_ack = 0;
      end else if (redir) begin
        fi = 1; fe = 1; m_fl_rem = FS_N; m_fl_first = 1; m_ack = 0;
      end else begin
        pw = 1; m_ack = 0;
      end
    end
    v = {pw, pl, fi, fe, si, se, ms, mb, md, st, m_tgt};
    if (st == 2'd0 && fi) begin
      m_tgt = toPC;
      tgt_q.push_back(toPC);
    end
  endtask

  task automatic drive(input bit ev, input bit bf, input bit bt, input bit j, input bit jr,
                       input logic [31:0] pc, input bit md, input bit st);
    logic [42:0] v;
    @(posedge clk); #1;
    exValid = ev; branchF = bf; branchTaken = bt; jumpF = j; jumpRF = jr;
    toPC = pc; mdReqF = md; memStallF = st;
    model_step(v);
    exp_q.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    exp_q.delete(); tgt_q.delete();
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    exValid = 0; branchF = 0; branchTaken = 0; jumpF = 0; jumpRF = 0;
    toPC = '0; mdReqF = 0; memStallF = 0;
    #1;
    chk("reset_outputs", 64'(dut_vec()), 64'({1'b1, 8'b0, 2'd0, 32'h0}));
    reset = 1'b0;
  endtask

  // monitor: compare one expectation per cycle, and newPC against the target queue on every load
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mdStartF) dut_starts++;
        if (mdDoneF) dut_dones++;
        if (exp_q.size() > 0) chk("cycle_outputs", 64'(dut_vec()), 64'(exp_q.pop_front()));
        if (pcLoadF) begin
          if (tgt_q.size() > 0) chk("load_target", 64'(newPC), 64'(tgt_q.pop_front()));
          else chk("load_without_redirect", 64'(pcLoadF), 64'(0));
        end
        if (pcLoadF && pcWriteF) chk("load_write_exclusive", 64'(1), 64'(0));
      end
    end
  end

  initial begin
    int s0, d0;
    model_reset();
    do_reset(3);
    idle(3);

    // taken branch
    drive(1, 1, 1, 0, 0, 32'h0040_0100, 0, 0);
    idle(4);

    // untaken branch, then JR
    drive(1, 1, 0, 0, 0, 32'h0badf00d, 0, 0);
    drive(1, 0, 0, 0, 1, 32'h1000_0008, 0, 0);
    idle(4);
    chk("jr_newpc_held", 64'(newPC), 64'(32'h1000_0008));

    // MD with mdReqF held through completion and the following RUN cycle
    s0 = dut_starts; d0 = dut_dones;
    for (int i = 0; i < MD_N + 2; i++) drive(1, 0, 0, 0, 0, 32'h0, 1, 0);
    idle(2);
    chk("md_single_start", 64'(dut_starts - s0), 64'(1));
    chk("md_single_done", 64'(dut_dones - d0), 64'(1));

    // stall coincident with redirect, then stall drops
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, 32'h2222_0040, 0, 1);
    drive(1, 0, 0, 1, 0, 32'h2222_0040, 0, 0);
    idle(4);
    chk("stall_redirect_newpc", 64'(newPC), 64'(32'h2222_0040));

    // reset during MD cycle 10
    d0 = dut_dones;
    drive(1, 0, 0, 0, 0, 32'h0, 1, 0);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    @(posedge clk); #1;
    chk("md_cycle10_busy", 64'(mdBusyF), 64'(1));
    reset = 1'b1;
    #1;
    chk("async_reset_state", 64'(state), 64'(0));
    chk("async_reset_busy", 64'(mdBusyF), 64'(0));
    chk("async_reset_done", 64'(mdDoneF), 64'(0));
    do_reset(2);
    idle(2);
    chk("no_done_after_reset", 64'(dut_dones - d0), 64'(0));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end
    idle(MD_N + 4);

    @(negedge clk); #1;
    chk("exp_queue_drained", 64'(exp_q.size()), 64'(0));
    chk("target_queue_drained", 64'(tgt_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
